// File: rtl/systolic_data_setup.sv
// Skewed operand feeder for the systolic MAC array: stores an N x N matrix
// and streams row i into lane i delayed by i cycles.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   wr_en/wr_row/wr_data  host row write (ignored while running)
//   start               begin one skewed emission of the stored matrix
//   busy                high during the 2N-1 step cycles
//   done                one-cycle pulse after the last step
//   a_out/a_valid       per-lane operand and valid to the array left edge
module systolic_data_setup #(
  parameter int N      = 2,
  parameter int DATA_W = 16,
  localparam int RW    = (N > 1) ? $clog2(N) : 1,
  localparam int CW    = $clog2(2 * N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [RW-1:0]         wr_row,
  input  logic [N*DATA_W-1:0]   wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [N*DATA_W-1:0]   a_out,
  output logic [N-1:0]          a_valid
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_nx;
  logic [N*DATA_W-1:0] bank [N];
  logic [N*DATA_W-1:0] step_data;
  logic [N-1:0]        step_vld;
  logic                last;

  assign last = (cnt == CW'(2 * N - 2));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        if (last) begin
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Lane i shows column (t - i) of row i once the diagonal reaches it.
  always_comb begin
    step_data = '0;
    step_vld  = '0;
    for (int i = 0; i < N; i++) begin
      int d;
      d = int'(cnt) - i;
      if (d >= 0 && d < N) begin
        step_data[i*DATA_W +: DATA_W] = bank[i][d*DATA_W +: DATA_W];
        step_vld[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      a_out   <= '0;
      a_valid <= '0;
      for (int r = 0; r < N; r++) begin
        bank[r] <= '0;
      end
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      busy  <= (state == RUN);
      done  <= (state == DONE);
      if (state == RUN) begin
        a_out   <= step_data;
        a_valid <= step_vld;
      end else begin
        a_out   <= '0;
        a_valid <= '0;
      end
      // The matrix is frozen while a run is reading it.
      if (wr_en && state != RUN && int'(wr_row) < N) begin
        bank[wr_row] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_systolic_data_setup.sv
// Bench for systolic_data_setup: a 2x2/16-bit and a 4x4/8-bit instance
// checked against a matrix-level model of the diagonal skew.
module tb_systolic_data_setup;

  logic clk = 1'b0;
  logic rst;

  logic        a_wr_en;
  logic [0:0]  a_wr_row;
  logic [31:0] a_wr_data;
  logic        a_start;
  logic        a_busy;
  logic        a_done;
  logic [31:0] a_out;
  logic [1:0]  a_vld;

  logic        b_wr_en;
  logic [1:0]  b_wr_row;
  logic [31:0] b_wr_data;
  logic        b_start;
  logic        b_busy;
  logic        b_done;
  logic [31:0] b_out;
  logic [3:0]  b_vld;

  int errors = 0;
  int checks = 0;
  int ma [2][2];
  int mb [4][4];

  always #5 clk = ~clk;

  systolic_data_setup #(.N(2), .DATA_W(16)) dut_a (
    .clk    (clk),
    .reset  (rst),
    .wr_en  (a_wr_en),
    .wr_row (a_wr_row),
    .wr_data(a_wr_data),
    .start  (a_start),
    .busy   (a_busy),
    .done   (a_done),
    .a_out  (a_out),
    .a_valid(a_vld)
  );

  systolic_data_setup #(.N(4), .DATA_W(8)) dut_b (
    .clk    (clk),
    .reset  (rst),
    .wr_en  (b_wr_en),
    .wr_row (b_wr_row),
    .wr_data(b_wr_data),
    .start  (b_start),
    .busy   (b_busy),
    .done   (b_done),
    .a_out  (b_out),
    .a_valid(b_vld)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a_idle(input string tag);
    chk({tag, "_out"}, 64'(a_out), 64'd0);
    chk({tag, "_vld"}, 64'(a_vld), 64'd0);
    chk({tag, "_busy"}, 64'(a_busy), 64'd0);
    chk({tag, "_done"}, 64'(a_done), 64'd0);
  endtask

  task automatic chk_b_idle(input string tag);
    chk({tag, "_out"}, 64'(b_out), 64'd0);
    chk({tag, "_vld"}, 64'(b_vld), 64'd0);
    chk({tag, "_busy"}, 64'(b_busy), 64'd0);
    chk({tag, "_done"}, 64'(b_done), 64'd0);
  endtask

  task automatic clear_models();
    foreach (ma[i, k]) ma[i][k] = 0;
    foreach (mb[i, k]) mb[i][k] = 0;
  endtask

  task automatic reset_all();
    rst = 1'b1;
    a_start = 1'b1;
    a_wr_en = 1'b1;
    a_wr_row = 1'b1;
    a_wr_data = $urandom;
    b_start = 1'b1;
    b_wr_en = 1'b1;
    b_wr_row = 2'd2;
    b_wr_data = $urandom;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk_a_idle("rst_a");
      chk_b_idle("rst_b");
    end
    rst = 1'b0;
    a_start = 1'b0;
    a_wr_en = 1'b0;
    b_start = 1'b0;
    b_wr_en = 1'b0;
    clear_models();
  endtask

  task automatic write_a(input int r, input int w0, input int w1);
    a_wr_en = 1'b1;
    a_wr_row = 1'(r);
    a_wr_data = {w1[15:0], w0[15:0]};
    tick();
    a_wr_en = 1'b0;
    ma[r][0] = w0;
    ma[r][1] = w1;
  endtask

  task automatic write_b(input int r, input int v [4]);
    b_wr_en = 1'b1;
    b_wr_row = 2'(r);
    b_wr_data = {v[3][7:0], v[2][7:0], v[1][7:0], v[0][7:0]};
    tick();
    b_wr_en = 1'b0;
    foreach (v[k]) mb[r][k] = v[k];
  endtask

  // One full run on the 2x2 instance. Optional same-cycle write with the
  // start, optional write/start noise during the run, and optionally leave
  // the bench inside the done cycle so the caller can chain another start.
  task automatic run_a(input bit disturb, input bit wr, input int wr_r,
                       input int w0, input int w1, input bit b2b);
    int el [2];
    int ev [2];
    a_start = 1'b1;
    if (wr) begin
      a_wr_en = 1'b1;
      a_wr_row = 1'(wr_r);
      a_wr_data = {w1[15:0], w0[15:0]};
      ma[wr_r][0] = w0;
      ma[wr_r][1] = w1;
    end
    tick();
    a_start = 1'b0;
    a_wr_en = 1'b0;
    chk("a_pre_busy", 64'(a_busy), 64'd0);
    chk("a_pre_vld", 64'(a_vld), 64'd0);
    for (int t = 0; t < 3; t++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        el[i] = 0;
        ev[i] = 0;
        if (t - i >= 0 && t - i < 2) begin
          el[i] = ma[i][t - i];
          ev[i] = 1;
        end
      end
      chk($sformatf("a_t%0d_l0", t), 64'(a_out[15:0]), 64'(el[0]));
      chk($sformatf("a_t%0d_l1", t), 64'(a_out[31:16]), 64'(el[1]));
      chk($sformatf("a_t%0d_vld", t), 64'(a_vld),
          64'(ev[1] * 2 + ev[0]));
      chk($sformatf("a_t%0d_busy", t), 64'(a_busy), 64'd1);
      chk($sformatf("a_t%0d_done", t), 64'(a_done), 64'd0);
      if (disturb && t < 2) begin
        a_wr_en = 1'b1;
        a_wr_row = 1'b0;
        a_wr_data = {16'd9, 16'd9};
        a_start = 1'b1;
      end else begin
        a_wr_en = 1'b0;
        a_start = 1'b0;
      end
    end
    tick();
    chk("a_done_pulse", 64'(a_done), 64'd1);
    chk("a_done_out", 64'(a_out), 64'd0);
    chk("a_done_vld", 64'(a_vld), 64'd0);
    chk("a_done_busy", 64'(a_busy), 64'd0);
    if (!b2b) begin
      tick();
      chk_a_idle("a_after");
      tick();
      chk_a_idle("a_after2");
    end
  endtask

  task automatic run_b();
    int el;
    int ev;
    logic [31:0] word;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk("b_pre_busy", 64'(b_busy), 64'd0);
    for (int t = 0; t < 7; t++) begin
      tick();
      word = '0;
      for (int i = 0; i < 4; i++) begin
        el = 0;
        ev = 0;
        if (t - i >= 0 && t - i < 4) begin
          el = mb[i][t - i];
          ev = 1;
        end
        word[i*8 +: 8] = el[7:0];
        chk($sformatf("b_t%0d_l%0d", t, i), 64'(b_out[i*8 +: 8]),
            64'(el));
        chk($sformatf("b_t%0d_v%0d", t, i), 64'(b_vld[i]), 64'(ev));
      end
      chk($sformatf("b_t%0d_busy", t), 64'(b_busy), 64'd1);
      chk($sformatf("b_t%0d_done", t), 64'(b_done), 64'd0);
      if (t == 3) chk("b_step3_word", 64'(b_out), 64'(word));
    end
    tick();
    chk("b_done_pulse", 64'(b_done), 64'd1);
    chk("b_done_out", 64'(b_out), 64'd0);
    chk("b_done_vld", 64'(b_vld), 64'd0);
    tick();
    chk_b_idle("b_after");
  endtask

  initial begin
    int row [4];
    a_wr_en = 1'b0;
    a_wr_row = '0;
    a_wr_data = '0;
    a_start = 1'b0;
    b_wr_en = 1'b0;
    b_wr_row = '0;
    b_wr_data = '0;
    b_start = 1'b0;
    clear_models();

    reset_all();
    run_a(1'b0, 1'b0, 0, 0, 0, 1'b0);

    write_a(0, 1, 2);
    write_a(1, 3, 4);
    run_a(1'b0, 1'b0, 0, 0, 0, 1'b0);

    run_a(1'b1, 1'b0, 0, 0, 0, 1'b0);
    run_a(1'b0, 1'b0, 0, 0, 0, 1'b0);

    run_a(1'b0, 1'b1, 1, 7, 8, 1'b0);

    run_a(1'b0, 1'b0, 0, 0, 0, 1'b1);
    run_a(1'b0, 1'b0, 0, 0, 0, 1'b0);

    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_a_idle("a_midrst");
    clear_models();
    tick();
    chk_a_idle("a_midrst2");
    run_a(1'b0, 1'b0, 0, 0, 0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) row[k] = 16 * i + k;
      write_b(i, row);
    end
    run_b();
    chk("b_fixed_l1", 64'(mb[1][2]), 64'd18);

    for (int n = 0; n < 6; n++) begin
      write_a(0, int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 65535)));
      write_a(1, int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 65535)));
      run_a(1'($urandom_range(0, 1)), 1'b0, 0, 0, 0,
            1'($urandom_range(0, 1)));
      for (int i = 0; i < 4; i++) begin
        for (int k = 0; k < 4; k++) row[k] = int'($urandom_range(0, 255));
        write_b(i, row);
      end
      run_b();
    end
    tick();
    chk_a_idle("a_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
